// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the team's FIFO family (single- and dual-clock).
//   - fifo_depth()  : DEPTH = 2**ADDR_SIZE without relying on $clog2
//   - fifo_err_t    : sticky error flag bundle {overflow, underflow}
//   - AE_THRESH_DEF / AF_MARGIN_DEF : default almost-empty threshold and the
//     distance of the default almost-full threshold below DEPTH
// -----------------------------------------------------------------------------
package fifo_pkg;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  localparam int AE_THRESH_DEF = 2;
  localparam int AF_MARGIN_DEF = 2;

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
//   DATA_SIZE x DEPTH register array with one synchronous write port and one
//   asynchronous read port. No reset: contents are only meaningful once written.
//   Ports:
//     clk_i    clock, rising edge
//     we_i     write enable (already qualified by accept/flush/reset)
//     waddr_i  write address
//     wdata_i  write data
//     raddr_i  read address
//     rdata_o  combinational read data, mem[raddr_i]
// -----------------------------------------------------------------------------
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//   Single-clock elastic buffer with occupancy count, programmable almost
//   thresholds, optional first-word-fall-through read, sticky error flags and
//   a synchronous flush.
//   Ports:
//     clk            clock, rising edge
//     rst            asynchronous active-low reset
//     flush          synchronous clear of contents and error flags
//     winc / wData   write request / data
//     rinc / rData   read request / data
//     wFull, rEmpty  occupancy == DEPTH / == 0 (registered)
//     wAlmost_full   count >= AF_THRESH (registered)
//     rAlmost_empty  count <= AE_THRESH (registered)
//     count          occupancy 0..DEPTH
//     overflow       sticky: write attempted while full
//     underflow      sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 4,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = fifo_depth(ADDR_SIZE) - AF_MARGIN_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wData,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rData,
  output logic                 wFull,
  output logic                 rEmpty,
  output logic                 wAlmost_full,
  output logic                 rAlmost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);
  localparam int CW    = ADDR_SIZE + 1;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (ADDR_SIZE < 1) begin : g_chk_addr
    $fatal(1, "sync_fifo_flags: ADDR_SIZE must be >= 1");
  end
  if (AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH - 1) begin : g_chk_thr
    $fatal(1, "sync_fifo_flags: need 1 <= AE_THRESH < AF_THRESH <= DEPTH-1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]        wptr_q, wptr_d;
  logic [CW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 afull_q, afull_d;
  logic                 aempty_q, aempty_d;
  fifo_err_t            err_q, err_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;

  logic                 wr_acc, rd_acc, ram_we;
  logic [DATA_SIZE-1:0] ram_rdata;

  // Accept decisions use the registered flags, so a full FIFO rejects a write
  // even when a read frees a slot in the same cycle (and vice versa).
  assign wr_acc = winc & ~full_q;
  assign rd_acc = rinc & ~empty_q;

  // Flush drops the write; rst gating keeps a write from landing in the array
  // during an edge that arrives while reset is held.
  assign ram_we = wr_acc & ~flush & rst;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_ram #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wptr_q[ADDR_SIZE-1:0]),
    .wdata_i (wData),
    .raddr_i (rptr_q[ADDR_SIZE-1:0]),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      err_d   = '0;
      rdata_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + CW'(1);
      if (rd_acc) begin
        rptr_d = rptr_q + CW'(1);
        // Registered-read mode captures the head word as it is popped.
        if (!FWFT) rdata_d = ram_rdata;
      end
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
      if (winc & full_q)  err_d.overflow  = 1'b1;
      if (rinc & empty_q) err_d.underflow = 1'b1;
    end
  end

  // Flags follow count_d so they change on the same edge as count.
  always_comb begin
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AF_THRESH));
    aempty_d = (count_d <= CW'(AE_THRESH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  if (FWFT) begin : g_fwft
    // Head word is presented straight from the array; forced to zero while
    // empty so reset and flush look the same as in registered mode.
    assign rData = empty_q ? '0 : ram_rdata;
  end else begin : g_reg
    assign rData = rdata_q;
  end

  assign wFull         = full_q;
  assign rEmpty        = empty_q;
  assign wAlmost_full  = afull_q;
  assign rAlmost_empty = aempty_q;
  assign count         = count_q;
  assign overflow      = err_q.overflow;
  assign underflow     = err_q.underflow;

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO, used where producer and consumer share `clk`.
- Adds:
  - an occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - a first-word-fall-through (FWFT) read mode;
  - sticky overflow and underflow error flags;
  - a synchronous flush.
- Sits between datapath stages as an elastic buffer. Its count and flags feed the flow-control logic.

Parameters:
- DATA_SIZE, 12, data word width in bits.
- ADDR_SIZE, 4, address bits; DEPTH = 2^ADDR_SIZE words.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2, wAlmost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, rAlmost_empty asserts when count <= AE_THRESH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of contents and error flags.
- winc  input  1  write request.
- wData  input  DATA_SIZE  write data.
- rinc  input  1  read request.
- rData  output  DATA_SIZE  read data.
- wFull  output  1  FIFO holds DEPTH words.
- rEmpty  output  1  FIFO holds 0 words.
- wAlmost_full  output  1  count >= AF_THRESH.
- rAlmost_empty  output  1  count <= AE_THRESH.
- count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers = 0 and count = 0.
  - rEmpty = 1, wFull = 0.
  - rAlmost_empty = 1, wAlmost_full = 0.
  - overflow = 0, underflow = 0.
  - rData = 0.
  - Memory contents are not reset.
- Pointers: binary, ADDR_SIZE+1 bits. The MSB is the wrap bit; the address is the low ADDR_SIZE bits. No gray coding.
- Accept rules: both are decided on the registered flags of the current cycle.
  - Write accepted = winc & ~wFull.
  - Read accepted = rinc & ~rEmpty.
- Simultaneous requests:
  - If both are accepted, count is unchanged and both pointers advance.
  - When full, a write is rejected even if a read occurs in the same cycle.
  - When empty, a read is rejected even if a write occurs in the same cycle.
- Count: count_next = count + wr_acc - rd_acc.
  - wFull, rEmpty, wAlmost_full and rAlmost_empty are registered.
  - They are computed from count_next, so they update in the same cycle as count.
- Write latency: a word written at edge N is readable (rEmpty = 0) after edge N.
- FWFT = 0:
  - rData is a register loaded with mem[raddr] on an accepted read, i.e. valid the cycle after the read.
  - rData holds its value otherwise.
- FWFT = 1:
  - rData = mem[raddr] whenever rEmpty = 0. This is a combinational read from the register array.
  - An accepted read advances to the next word on the following cycle.
  - rData is don't-care while empty.
- Wrap-around: pointers roll over from 2*DEPTH-1 to 0. Full and empty are derived from count, never from pointer compare.
- Error flags:
  - overflow is set on winc & wFull; underflow is set on rinc & rEmpty.
  - Both stay set until flush or reset. The offending request has no effect on the pointers.
- flush:
  - Has priority over winc and rinc in the same cycle; those requests are ignored.
  - Next state: pointers = 0 and count = 0, with flags at their reset values.
  - overflow and underflow are cleared.
  - rData is cleared to 0 when FWFT = 0.
- Reset asserted mid-operation aborts immediately to the reset state; no partial write completes.
- Elaboration checks: 1 <= AE_THRESH < AF_THRESH <= DEPTH-1 and ADDR_SIZE >= 1. A violation is a fatal error.

Decomposition:
- Package fifo_pkg:
  - function clog2-free DEPTH helper;
  - typedef for the fifo_err_t {overflow, underflow} struct;
  - default threshold localparams shared with the dual-clock FIFO.
- Sub-module fifo_ram:
  - DATA_SIZE x DEPTH register array;
  - write port on clk gated by wr_acc;
  - asynchronous read port addressed by raddr.
- The top level holds the pointers, count, flags and the rData register or mux.

Test Plan (DATA_SIZE=8, ADDR_SIZE=2 so DEPTH=4, AF_THRESH=3, AE_THRESH=1, FWFT=0 unless noted):
1. Reset, then idle:
   - count=0, rEmpty=1, wFull=0, rAlmost_empty=1, wAlmost_full=0, overflow=0, underflow=0, rData=0.
2. Fill to full:
   - Write 0x11,0x22,0x33,0x44 on consecutive cycles.
   - count steps 1,2,3,4; wAlmost_full rises with count=3; wFull=1 at count=4.
   - A 5th write of 0x55 sets overflow=1 and leaves count=4.
3. Drain:
   - Four reads return rData 0x11,0x22,0x33,0x44, each one cycle after its read.
   - rEmpty=1 after the last read.
   - A further rinc sets underflow=1 and leaves rData=0x44.
4. Simultaneous read and write at count=2 for 6 cycles:
   - count stays 2 and data order is preserved across pointer wrap.
   - At full, rinc+winc pops one word, rejects the write, count=3, overflow=1.
5. FWFT=1:
   - Write 0xA5: rData=0xA5 with rEmpty=0 the next cycle, without rinc.
   - rinc pops it; rEmpty=1.
6. Flush and reset:
   - flush with winc=1 at count=3 and overflow=1 gives count=0, rEmpty=1, overflow=0, with the write ignored.
   - rst pulsed low mid-burst returns all outputs to their reset values asynchronously.
